// File: rtl/signmag_to_twos_pkg.sv
// signmag_to_twos_pkg: shared widths and range limits for the sign-magnitude converter
package signmag_to_twos_pkg;
    localparam int W_DEF = 32;
    localparam int CW_DEF = 16;
    localparam logic [W_DEF-1:0] POS_MAX = {1'b0, {(W_DEF-1){1'b1}}};
    localparam logic [W_DEF-1:0] NEG_MAX_MAG = {1'b1, {(W_DEF-1){1'b0}}};
endpackage

// File: rtl/sm_range_check.sv
// sm_range_check: flags magnitudes that do not fit a W-bit two's-complement value
// ports: sign (1 = negative), mag (unsigned magnitude), sat (out of range)
module sm_range_check
    import signmag_to_twos_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic         sign,
    input  logic [W-1:0] mag,
    output logic         sat
);
    localparam logic [W-1:0] pos_lim = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] neg_lim = {1'b1, {(W-1){1'b0}}};
    always_comb sat = sign ? (mag > neg_lim) : (mag > pos_lim);
endmodule

// File: rtl/signmag_to_twos.sv
// signmag_to_twos: two-stage valid/ready sign-magnitude to two's-complement converter with saturation
// ports: clk, rst_n (async, active low); mag_in/sign_in/in_valid/in_ready input side;
//        dataout/ovf_out/out_valid/out_ready output side; ovf_cnt saturating overflow count, cnt_clr clears it
module signmag_to_twos
    import signmag_to_twos_pkg::*;
#(
    parameter int W  = W_DEF,
    parameter int CW = CW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [W-1:0]  mag_in,
    input  logic          sign_in,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [W-1:0]  dataout,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          ovf_out,
    output logic [CW-1:0] ovf_cnt,
    input  logic          cnt_clr
);
    localparam logic [W-1:0] pos_max = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] neg_max = ~pos_max;
    logic         s1_valid, s1_sign, s1_sat, in_sat, s2_adv;
    logic [W-1:0] s1_mag, conv;
    sm_range_check #(.W(W)) u_range (
        .sign(sign_in),
        .mag (mag_in),
        .sat (in_sat)
    );
    assign s2_adv   = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_adv;
    always_comb conv = s1_sat ? (s1_sign ? neg_max : pos_max) : (s1_sign ? -s1_mag : s1_mag);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_sign   <= 1'b0;
            s1_sat    <= 1'b0;
            s1_mag    <= '0;
            out_valid <= 1'b0;
            dataout   <= '0;
            ovf_out   <= 1'b0;
            ovf_cnt   <= '0;
        end else begin
            if (in_valid && in_ready) begin
                s1_valid <= 1'b1;
                s1_sign  <= sign_in;
                s1_sat   <= in_sat;
                s1_mag   <= mag_in;
            end else if (s2_adv) begin
                s1_valid <= 1'b0;
            end
            if (s2_adv) out_valid <= s1_valid;
            // an empty stage 1 leaves the last word in place rather than loading stale data
            if (s2_adv && s1_valid) begin
                dataout <= conv;
                ovf_out <= s1_sat;
            end
            if (cnt_clr) ovf_cnt <= '0;
            else if (out_valid && out_ready && ovf_out && ovf_cnt != '1) ovf_cnt <= ovf_cnt + CW'(1);
        end
    end
endmodule

// File: tb/tb_signmag_to_twos.sv
// tb_signmag_to_twos: directed and round-trip checks of signmag_to_twos against an arithmetic model
module tb_signmag_to_twos;
    import signmag_to_twos_pkg::*;
    localparam int W = 32;
    localparam int CW = 16;
    logic clk = 1'b0, rst_n = 1'b0;
    logic [W-1:0] mag_in = '0;
    logic sign_in = 1'b0, in_valid = 1'b0, out_ready = 1'b1, cnt_clr = 1'b0;
    logic in_ready, out_valid, ovf_out;
    logic [W-1:0] dataout;
    logic [CW-1:0] ovf_cnt;
    signmag_to_twos #(.W(W), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .mag_in(mag_in), .sign_in(sign_in),
        .in_valid(in_valid), .in_ready(in_ready), .dataout(dataout),
        .out_valid(out_valid), .out_ready(out_ready), .ovf_out(ovf_out),
        .ovf_cnt(ovf_cnt), .cnt_clr(cnt_clr)
    );
    always #5 clk = ~clk;
    typedef struct {logic [W-1:0] d; logic o; int acc;} exp_t;
    exp_t exp_q[$];
    logic [W:0] got_q[$];
    logic [W-1:0] rt_q[$];
    logic [CW-1:0] cnt_m = '0;
    int errors = 0, checks = 0, cyc = 0;
    bit chk_lat = 0, rt_mode = 0, prev_stall = 0;
    logic [W-1:0] prev_d = '0;
    logic prev_o = 1'b0;
    logic s_t [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [W-1:0] m_t [7] = '{32'd5, 32'd5, 32'd0, 32'h7FFFFFFF, 32'h80000000, 32'h80000000, 32'hFFFFFFFF};
    logic [W-1:0] d_t [7] = '{32'h5, 32'hFFFFFFFB, 32'h0, 32'h7FFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h80000000};
    logic o_t [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    always @(posedge clk) cyc <= cyc + 1;
    task automatic check(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask
    function automatic logic [W:0] model(logic s, logic [W-1:0] m);
        longint v, pmax, nmin;
        pmax = {32'b0, POS_MAX};
        nmin = {32'b0, NEG_MAX_MAG};
        nmin = -nmin;
        v = {32'b0, m};
        if (s) v = -v;
        if (v > pmax) return {1'b1, POS_MAX};
        if (v < nmin) return {1'b1, NEG_MAX_MAG};
        return {1'b0, v[W-1:0]};
    endfunction
    always @(negedge clk) begin : mon
        exp_t e;
        logic [W:0] r;
        logic xo;
        if (rst_n) begin
            xo = 1'b0;
            check("in_ready", {63'b0, in_ready}, {63'b0, out_ready || exp_q.size() < 2});
            check("ovf_cnt", {48'b0, ovf_cnt}, {48'b0, cnt_m});
            if (out_valid && exp_q.size() == 0) check("spurious_valid", {63'b0, out_valid}, 64'd0);
            if (prev_stall) begin
                check("hold_valid", {63'b0, out_valid}, 64'd1);
                check("hold_data", {32'b0, dataout}, {32'b0, prev_d});
                check("hold_ovf", {63'b0, ovf_out}, {63'b0, prev_o});
            end
            if (out_valid && out_ready && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                xo = e.o;
                check("data", {32'b0, dataout}, {32'b0, e.d});
                check("ovf_out", {63'b0, ovf_out}, {63'b0, e.o});
                if (chk_lat) check("latency", 64'(cyc - e.acc), 64'd2);
                got_q.push_back({ovf_out, dataout});
                if (rt_mode && rt_q.size() > 0) check("roundtrip", {32'b0, dataout}, {32'b0, rt_q.pop_front()});
            end
            prev_stall = out_valid && !out_ready;
            prev_d = dataout;
            prev_o = ovf_out;
            cnt_m = cnt_clr ? '0 : (xo && cnt_m != '1) ? cnt_m + 1'b1 : cnt_m;
            if (in_valid && in_ready) begin
                r = model(sign_in, mag_in);
                exp_q.push_back('{d: r[W-1:0], o: r[W], acc: cyc});
            end
        end
    end
    task automatic send(logic s, logic [W-1:0] m);
        int n = 0;
        bit acc;
        sign_in = s;
        mag_in = m;
        in_valid = 1'b1;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 50);
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready stayed %b, required 1", in_ready);
        end
        in_valid = 1'b0;
    endtask
    task automatic drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain", 64'(exp_q.size()), 64'd0);
    endtask
    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
    initial begin
        logic [W-1:0] v, m;
        #12;
        check("rst_data", {32'b0, dataout}, 64'd0);
        check("rst_valid", {63'b0, out_valid}, 64'd0);
        check("rst_ovf", {63'b0, ovf_out}, 64'd0);
        check("rst_cnt", {48'b0, ovf_cnt}, 64'd0);
        check("rst_in_ready", {63'b0, in_ready}, 64'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk_lat = 1;
        got_q.delete();
        for (int i = 0; i < 7; i++) send(s_t[i], m_t[i]);
        drain();
        check("dir_count", 64'(got_q.size()), 64'd7);
        for (int i = 0; i < 7 && i < got_q.size(); i++)
            check($sformatf("dir_vec%0d", i), {31'b0, got_q[i]}, {31'b0, o_t[i], d_t[i]});
        check("edge_ovf_cnt", {48'b0, ovf_cnt}, 64'd2);
        chk_lat = 0;
        got_q.delete();
        fork
            for (int i = 0; i < 10; i++) send(1'b0, 32'd100 + 32'(i));
            begin
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1;
                check("bp_in_ready_low", {63'b0, in_ready}, 64'd0);
                check("bp_out_valid", {63'b0, out_valid}, 64'd1);
                out_ready = 1'b1;
                #1;
                check("bp_in_ready_rise", {63'b0, in_ready}, 64'd1);
            end
        join
        drain();
        check("bp_count", 64'(got_q.size()), 64'd10);
        for (int i = 0; i < 10 && i < got_q.size(); i++)
            check($sformatf("bp_order%0d", i), {31'b0, got_q[i]}, 64'd100 + 64'(i));
        chk_lat = 1;
        for (int i = 0; i < 70000; i++) send(1'b0, 32'hFFFFFFFF);
        drain();
        check("cnt_saturated", {48'b0, ovf_cnt}, 64'hFFFF);
        send(1'b1, 32'h90000000);
        @(posedge clk);
        #1;
        check("clr_xfer_valid", {63'b0, out_valid}, 64'd1);
        check("clr_xfer_ovf", {63'b0, ovf_out}, 64'd1);
        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        check("cnt_clr", {48'b0, ovf_cnt}, 64'd0);
        send(1'b0, 32'hA0000000);
        send(1'b1, 32'hA0000000);
        drain();
        check("cnt_after_clr", {48'b0, ovf_cnt}, 64'd2);
        chk_lat = 0;
        out_ready = 1'b0;
        send(1'b0, 32'd7);
        send(1'b1, 32'd9);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {63'b0, out_valid}, 64'd0);
        check("mid_rst_data", {32'b0, dataout}, 64'd0);
        check("mid_rst_cnt", {48'b0, ovf_cnt}, 64'd0);
        exp_q.delete();
        prev_stall = 0;
        cnt_m = '0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_lat = 1;
        send(1'b0, 32'd42);
        check("post_rst_not_yet", {63'b0, out_valid}, 64'd0);
        @(posedge clk);
        #1;
        check("post_rst_valid", {63'b0, out_valid}, 64'd1);
        check("post_rst_data", {32'b0, dataout}, 64'd42);
        drain();
        rt_mode = 1;
        for (int i = 0; i < 10000; i++) begin
            v = (i == 0) ? 32'h80000000 : (i == 1) ? 32'h0 : $urandom;
            m = v[W-1] ? -v : v;
            rt_q.push_back(v);
            send(v[W-1], m);
        end
        drain();
        check("rt_left", 64'(rt_q.size()), 64'd0);
        rt_mode = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/signmag_to_twos.md
Name: signmag_to_twos

Overview:
- Streaming converter from sign-magnitude to two's complement, the inverse of the filter path's two's-complement-to-sign-magnitude stage.
- Feeds processed magnitudes plus sign back into signed arithmetic, e.g. the filter output toward the motor PWM/PID datapath.
- Two-stage valid/ready pipeline with saturation on out-of-range magnitudes and a saturating overflow event counter.

Parameters:
- W, 32, data width of magnitude input and two's-complement output
- CW, 16, width of overflow event counter

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- mag_in  input  W  unsigned magnitude
- sign_in  input  1  1 = negative
- in_valid  input  1  input word present
- in_ready  output  1  block accepts input this cycle
- dataout  output  W  two's-complement result
- out_valid  output  1  dataout valid
- out_ready  input  1  downstream accepts
- ovf_out  output  1  current output word was saturated (qualified by out_valid)
- ovf_cnt  output  CW  count of saturated words delivered
- cnt_clr  input  1  synchronous clear of ovf_cnt

Behaviour:
- Reset (async, rst_n low): dataout=0, out_valid=0, ovf_out=0, ovf_cnt=0, all stage valids 0, pipeline contents 0. Reset mid-stream discards all in-flight words.
- Handshake:
  - Transfer on in_valid&&in_ready (input) and out_valid&&out_ready (output).
  - dataout/ovf_out hold stable while out_valid&&!out_ready.
  - in_ready is combinational: in_ready = !s1_valid || s2_adv, where s2_adv = !out_valid || out_ready.
- Stage 1, loads on input transfer:
  - Registers sign, mag and a saturate flag.
  - Saturate when sign=0 && mag > 2^(W-1)-1, or sign=1 && mag > 2^(W-1).
  - s1_valid clears when s1 moves to s2 with no new input.
- Stage 2, loads when s2_adv:
  - sat && sign=0 -> 2^(W-1)-1.
  - sat && sign=1 -> 2^(W-1), i.e. the most negative value.
  - !sat && sign=0 -> mag.
  - !sat && sign=1 -> 0 - mag, modulo 2^W.
  - ovf_out = sat.
- Negative zero (sign=1, mag=0) -> dataout=0, ovf_out=0.
- mag = 2^(W-1) with sign=1 -> dataout=2^(W-1), not an overflow.
- Latency: 2 cycles from input transfer to out_valid with no stalls. Throughput 1 word/cycle when out_ready is held high.
- Ordering: strictly in order; no words are dropped or duplicated under any stall pattern.
- Backpressure: with out_ready low, at most 2 words are held, after which in_ready=0. The cycle out_ready rises, in_ready rises in the same cycle.
- ovf_cnt:
  - Increments on each output transfer with ovf_out=1.
  - Saturates at 2^CW-1 (no wrap).
  - cnt_clr has priority: a coincident increment is lost and the count becomes 0 next cycle.

Decomposition:
- Shared package holds:
  - Constants derived from W: POS_MAX = 2^(W-1)-1 and NEG_MAX_MAG = 2^(W-1).
  - Default widths W and CW.
- One natural sub-module: sm_range_check (combinational saturate-flag compute from sign/mag/W). Everything else lives in the top.

Test Plan (W=32, CW=16):
- Basic conversion, out_ready=1, one word per cycle:
  - (sign=0, mag=5) -> 0x00000005.
  - (sign=1, mag=5) -> 0xFFFFFFFB.
  - (sign=1, mag=0) -> 0x00000000.
  - Each appears exactly 2 cycles after acceptance, ovf_out=0.
- Range edges:
  - (0, 0x7FFFFFFF) -> 0x7FFFFFFF, ovf 0.
  - (1, 0x80000000) -> 0x80000000, ovf 0.
  - (0, 0x80000000) -> 0x7FFFFFFF, ovf 1.
  - (1, 0xFFFFFFFF) -> 0x80000000, ovf 1.
  - ovf_cnt ends at 2.
- Backpressure:
  - Stream 10 words with out_ready low for 5 cycles mid-stream -> in_ready drops after 2 words are buffered.
  - dataout stays stable while stalled.
  - All 10 words emerge in order with no loss or duplication.
- Counter:
  - 70000 saturating words -> ovf_cnt saturates at 0xFFFF.
  - cnt_clr asserted coincident with a saturated output transfer -> ovf_cnt=0 the next cycle.
- Reset mid-operation:
  - Drop rst_n with 2 words in flight -> out_valid=0 and dataout=0 immediately (asynchronously), ovf_cnt=0.
  - After release, the first new input appears 2 cycles after acceptance.
- Round-trip: random 32-bit two's-complement values go through the sign-magnitude split and back through this block -> bit-exact match, ovf_out=0, over 10k vectors including 0x80000000.
